down_timer_controller: RTL
==========================

// Module: down_timer_controller
// PURPOSE
//   Run-control FSM for the four-digit BCD down-counting display timer.
//   Debounces four raw push-buttons and sequences the counter chain through its phases:
//   edit preset, run, pause, expire/alarm. It drives the chain's enable and load.
//   Sits between the board buttons and the BCD down-counter datapath.
//   Paced by the datapath's prescaler strobe (TICK).
// PARAMETERS
//   PRESET_DEFAULT  16'h1000  BCD preset {d3,d2,d1,d0} after reset (10.00)
//   DB_TICKS        3         consecutive TICK samples a button must be stable
//   ALARM_TICKS     500       TICK strobes ALARM stays high before auto-return
//   BLINK_TICKS     50        TICK strobes per BLINK half-period in SET
// PORTS
//   CLK           in   1   system clock, all logic rising-edge
//   RESET         in   1   asynchronous, active-low reset
//   TICK          in   1   one-CLK strobe from the datapath prescaler
//   BTN_START     in   1   raw button, async to CLK, active-high
//   BTN_STOP      in   1   raw button, async to CLK, active-high
//   BTN_MODE      in   1   raw button, async to CLK, active-high
//   BTN_INC       in   1   raw button, async to CLK, active-high
//   COUNT_ZERO    in   1   datapath: all four digits == 0
//   COUNT_ENABLE  out  1   gate for the down-counter chain ENABLE
//   COUNT_LOAD    out  1   one-CLK pulse: datapath loads PRESET
//   PRESET        out  16  BCD preset value, 4 digits
//   EDIT_DIGIT    out  2   digit under edit (0 = least significant)
//   BLINK         out  1   blink phase for the edited digit; 0 outside SET
//   ALARM         out  1   high in EXPIRED
//   STATE         out  3   IDLE=0 SET=1 RUN=2 PAUSE=3 EXPIRED=4
// BEHAVIOUR
//   Reset (RESET=0, immediate, no clock needed):
//     - STATE=IDLE, PRESET=PRESET_DEFAULT, EDIT_DIGIT=0.
//     - BLINK, ALARM, COUNT_LOAD, COUNT_ENABLE all 0.
//     - Sync flops, debounce counters and debounced levels all 0.
//   Button input path:
//     - Each button passes a 2-flop synchroniser.
//     - Debounced level takes the synced value after DB_TICKS consecutive TICKs
//       with synced != debounced. The count clears on any TICK where they are equal.
//     - A rising edge of the debounced level gives a 1-CLK press pulse.
//     - Same-cycle presses: priority STOP > START > MODE > INC; only the winner acts.
//   COUNT_ENABLE = (STATE==RUN) & ~COUNT_ZERO. Combinational, so the chain never
//   wraps below 0000.
//   Every "-> IDLE + load" transition asserts COUNT_LOAD for exactly the one CLK
//   in which STATE becomes IDLE.
//   IDLE:
//     - START with PRESET != 0 -> RUN.
//     - START with PRESET == 0 is ignored.
//     - MODE -> SET with EDIT_DIGIT=0.
//   SET:
//     - INC: selected digit +1; 9 wraps to 0 with no carry.
//     - MODE: EDIT_DIGIT +1; MODE on digit 3 -> IDLE + load.
//     - STOP -> IDLE + load.
//     - BLINK toggles every BLINK_TICKS TICKs.
//   RUN:
//     - COUNT_ZERO -> EXPIRED; this takes priority over STOP.
//     - STOP -> PAUSE.
//     - START, MODE and INC are ignored.
//   PAUSE:
//     - START -> RUN.
//     - STOP -> IDLE + load.
//   EXPIRED:
//     - ALARM=1.
//     - After ALARM_TICKS TICKs -> IDLE + load.
//     - Any press before that -> IDLE + load immediately.
//   Latency: press edge -> STATE change on the next CLK edge.
// TESTING (bench: TICK every 4 CLK, DB_TICKS=2, ALARM_TICKS=4, BLINK_TICKS=2)
//   1. MODE; INC x3; INC x10 on digit0 -> PRESET=16'h1003 (10 INCs wrap to same digit);
//      MODE x4 -> IDLE, COUNT_LOAD high for exactly 1 CLK.
//   2. IDLE, START -> STATE=2, COUNT_ENABLE=1.
//      Then STOP -> STATE=3, COUNT_ENABLE=0; START -> STATE=2.
//      Then STOP, STOP -> STATE=0 with a 1-CLK COUNT_LOAD.
//   3. RUN, COUNT_ZERO=1 -> COUNT_ENABLE=0 in the same cycle; STATE=4 next CLK;
//      ALARM=1 for 4 TICKs; then STATE=0 with COUNT_LOAD pulse.
//   4. BTN_START high for 1 TICK only -> no state change.
//      Then START+STOP rising together in PAUSE -> STATE=0 (STOP wins).
//   5. PRESET=16'h0000 in IDLE, START -> STATE stays 0, COUNT_ENABLE stays 0.
//   6. RESET low mid-RUN, between clock edges -> all outputs at reset values
//      before the next edge; PRESET=16'h1000.

Source files
------------

// File: rtl/down_timer_controller.sv
// Run-control FSM for the four-digit BCD down-counting display timer.
// Latency: a debounced press edge changes STATE on the next CLK edge; COUNT_ENABLE is combinational.
// Backpressure: none. Buttons are sampled on TICK, and presses that lose the same-cycle priority are dropped.
module down_timer_controller #(
  parameter logic [15:0] PRESET_DEFAULT = 16'h1000,
  parameter int          DB_TICKS       = 3,
  parameter int          ALARM_TICKS    = 500,
  parameter int          BLINK_TICKS    = 50
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        TICK,
  input  logic        BTN_START,
  input  logic        BTN_STOP,
  input  logic        BTN_MODE,
  input  logic        BTN_INC,
  input  logic        COUNT_ZERO,
  output logic        COUNT_ENABLE,
  output logic        COUNT_LOAD,
  output logic [15:0] PRESET,
  output logic [1:0]  EDIT_DIGIT,
  output logic        BLINK,
  output logic        ALARM,
  output logic [2:0]  STATE
);

  localparam int DBW = $clog2(DB_TICKS + 1);
  localparam int ALW = $clog2(ALARM_TICKS + 1);
  localparam int BLW = $clog2(BLINK_TICKS + 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SET     = 3'd1,
    ST_RUN     = 3'd2,
    ST_PAUSE   = 3'd3,
    ST_EXPIRED = 3'd4
  } state_t;

  // Button bit order: 0 = START, 1 = STOP, 2 = MODE, 3 = INC
  logic [3:0]          btn_raw;
  logic [3:0]          sync1_q, sync1_d, sync2_q, sync2_d;
  logic [3:0][DBW-1:0] db_cnt_q, db_cnt_d;
  logic [3:0]          db_lvl_q, db_lvl_d, db_dly_q, db_dly_d;
  logic [3:0]          press;
  logic                pr_start, pr_stop, pr_mode, pr_inc, any_press;

  state_t              state_q, state_d;
  logic [15:0]         preset_q, preset_d;
  logic [1:0]          edit_q, edit_d;
  logic                blink_q, blink_d;
  logic [BLW-1:0]      blink_cnt_q, blink_cnt_d;
  logic [ALW-1:0]      alarm_cnt_q, alarm_cnt_d;
  logic                load_q, load_d;
  logic [3:0]          cur_digit;

  assign btn_raw = {BTN_INC, BTN_MODE, BTN_STOP, BTN_START};

  // Two-flop synchroniser, then a per-button debounce counter advanced only on TICK
  always_comb begin
    sync1_d  = btn_raw;
    sync2_d  = sync1_q;
    db_dly_d = db_lvl_q;
    db_cnt_d = db_cnt_q;
    db_lvl_d = db_lvl_q;
    if (TICK) begin
      for (int i = 0; i < 4; i++) begin
        if (sync2_q[i] != db_lvl_q[i]) begin
          if (db_cnt_q[i] == DBW'(DB_TICKS - 1)) begin
            db_lvl_d[i] = sync2_q[i];
            db_cnt_d[i] = '0;
          end else begin
            db_cnt_d[i] = db_cnt_q[i] + 1'b1;
          end
        end else begin
          db_cnt_d[i] = '0;
        end
      end
    end
  end

  // One-CLK press pulses; a single winner per cycle, STOP > START > MODE > INC
  assign press     = db_lvl_q & ~db_dly_q;
  assign pr_stop   = press[1];
  assign pr_start  = press[0] & ~press[1];
  assign pr_mode   = press[2] & ~press[1] & ~press[0];
  assign pr_inc    = press[3] & ~press[2] & ~press[1] & ~press[0];
  assign any_press = |press;
  assign cur_digit = preset_q[{edit_q, 2'b00} +: 4];

  // Next-state logic. COUNT_LOAD is registered so it is high exactly in the first IDLE cycle.
  always_comb begin
    state_d     = state_q;
    preset_d    = preset_q;
    edit_d      = edit_q;
    blink_d     = 1'b0;
    blink_cnt_d = '0;
    alarm_cnt_d = '0;
    load_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pr_start && (preset_q != 16'h0000)) begin
          state_d = ST_RUN;
        end else if (pr_mode) begin
          state_d = ST_SET;
          edit_d  = 2'd0;
        end
      end
      ST_SET: begin
        blink_d     = blink_q;
        blink_cnt_d = blink_cnt_q;
        if (TICK) begin
          if (blink_cnt_q == BLW'(BLINK_TICKS - 1)) begin
            blink_cnt_d = '0;
            blink_d     = ~blink_q;
          end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
          end
        end
        if (pr_stop || (pr_mode && (edit_q == 2'd3))) begin
          state_d     = ST_IDLE;
          load_d      = 1'b1;
          edit_d      = 2'd0;
          blink_d     = 1'b0;
          blink_cnt_d = '0;
        end else if (pr_mode) begin
          edit_d = edit_q + 2'd1;
        end else if (pr_inc) begin
          preset_d[{edit_q, 2'b00} +: 4] = (cur_digit == 4'd9) ? 4'd0 : cur_digit + 4'd1;
        end
      end
      ST_RUN: begin
        if (COUNT_ZERO) begin
          state_d = ST_EXPIRED;
        end else if (pr_stop) begin
          state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (pr_stop) begin
          state_d = ST_IDLE;
          load_d  = 1'b1;
        end else if (pr_start) begin
          state_d = ST_RUN;
        end
      end
      ST_EXPIRED: begin
        alarm_cnt_d = alarm_cnt_q;
        if (any_press || (TICK && (alarm_cnt_q == ALW'(ALARM_TICKS - 1)))) begin
          state_d     = ST_IDLE;
          load_d      = 1'b1;
          alarm_cnt_d = '0;
        end else if (TICK) begin
          alarm_cnt_d = alarm_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register, asynchronously cleared to the power-on values
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      db_cnt_q    <= '0;
      db_lvl_q    <= '0;
      db_dly_q    <= '0;
      state_q     <= ST_IDLE;
      preset_q    <= PRESET_DEFAULT;
      edit_q      <= 2'd0;
      blink_q     <= 1'b0;
      blink_cnt_q <= '0;
      alarm_cnt_q <= '0;
      load_q      <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      db_cnt_q    <= db_cnt_d;
      db_lvl_q    <= db_lvl_d;
      db_dly_q    <= db_dly_d;
      state_q     <= state_d;
      preset_q    <= preset_d;
      edit_q      <= edit_d;
      blink_q     <= blink_d;
      blink_cnt_q <= blink_cnt_d;
      alarm_cnt_q <= alarm_cnt_d;
      load_q      <= load_d;
    end
  end

  assign STATE        = state_q;
  assign COUNT_ENABLE = (state_q == ST_RUN) & ~COUNT_ZERO;
  assign COUNT_LOAD   = load_q;
  assign PRESET       = preset_q;
  assign EDIT_DIGIT   = edit_q;
  assign BLINK        = blink_q;
  assign ALARM        = (state_q == ST_EXPIRED);

endmodule
